// File: rtl/intpol2_run_ctrl.sv
// Run controller for the interpolator core: loads four config words, computes the
// expected output count, starts the core and tracks its writes until done or error.
module intpol2_run_ctrl #(
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      go_i,
  input  logic                      abort_i,
  input  logic [ADDR_WIDTH-1:0]     sig_len_i,
  output logic                      cfg_rd_o,
  output logic [1:0]                cfg_addr_o,
  input  logic [CONFIG_WIDTH-1:0]   cfg_data_i,
  output logic [4*CONFIG_WIDTH-1:0] config_reg_o,
  output logic                      core_start_o,
  input  logic                      core_we_i,
  input  logic                      core_done_i,
  output logic [ADDR_WIDTH-1:0]     total_len_o,
  output logic [ADDR_WIDTH-1:0]     out_cnt_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int PW = 2 * ADDR_WIDTH;
  localparam int CW = $clog2(ADDR_WIDTH + 1);
  localparam logic [CW-1:0]         CALC_LAST = CW'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LEN_MIN   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] LEN_TAPS  = ADDR_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                    state_r, state_s;
  logic [2:0]                ld_cnt_r, ld_cnt_s;
  logic [CW-1:0]             calc_cnt_r, calc_cnt_s;
  logic [ADDR_WIDTH-1:0]     sig_len_r, sig_len_s;
  logic [PW-1:0]             mcand_r, mcand_s, prod_r, prod_s, prod_step_s;
  logic [ADDR_WIDTH-1:0]     mplier_r, mplier_s;
  logic [4*CONFIG_WIDTH-1:0] config_r, config_s;
  logic [ADDR_WIDTH-1:0]     total_r, total_s, cnt_r, cnt_s, cnt_inc_s, ilen_s;
  logic                      err_r, err_s;
  logic                      busy_r, done_r, start_r, cfg_rd_r, cfg_rd_s;
  logic [1:0]                cfg_addr_r;

  assign ilen_s      = config_r[3*CONFIG_WIDTH +: ADDR_WIDTH];
  assign prod_step_s = prod_r + (mplier_r[0] ? mcand_r : {PW{1'b0}});
  assign cnt_inc_s   = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, core_we_i};
  assign cfg_rd_s    = (state_s == S_LOAD) && (ld_cnt_s < 3'd4);

  // Next-state and datapath update; abort overrides every other event.
  always_comb begin
    state_s    = state_r;
    ld_cnt_s   = ld_cnt_r;
    calc_cnt_s = calc_cnt_r;
    sig_len_s  = sig_len_r;
    mcand_s    = mcand_r;
    mplier_s   = mplier_r;
    prod_s     = prod_r;
    config_s   = config_r;
    total_s    = total_r;
    cnt_s      = cnt_r;
    err_s      = err_r;
    if ((state_r != S_IDLE) && abort_i) begin
      state_s = S_IDLE;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go_i) begin
            sig_len_s = sig_len_i;
            cnt_s     = {ADDR_WIDTH{1'b0}};
            err_s     = 1'b0;
            ld_cnt_s  = 3'd0;
            state_s   = S_LOAD;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LOAD: begin
          // Read data lags the strobe by one cycle, so capture trails by one index.
          case (ld_cnt_r)
            3'd1:    config_s[0*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_data_i;
            3'd2:    config_s[1*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_data_i;
            3'd3:    config_s[2*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_data_i;
            3'd4:    config_s[3*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg_data_i;
            default: config_s = config_r;
          endcase
          if (ld_cnt_r == 3'd4) begin
            calc_cnt_s = {CW{1'b0}};
            state_s    = S_CALC;
          end else begin
            ld_cnt_s = ld_cnt_r + 3'd1;
          end
        end
        S_CALC: begin
          if (calc_cnt_r == {CW{1'b0}}) begin
            if ((sig_len_r < LEN_MIN) || (ilen_s == {ADDR_WIDTH{1'b0}})) begin
              err_s   = 1'b1;
              state_s = S_FIN;
            end else begin
              mcand_s    = {{ADDR_WIDTH{1'b0}}, sig_len_r - LEN_TAPS};
              mplier_s   = ilen_s;
              prod_s     = {PW{1'b0}};
              calc_cnt_s = calc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            prod_s   = prod_step_s;
            mcand_s  = {mcand_r[PW-2:0], 1'b0};
            mplier_s = {1'b0, mplier_r[ADDR_WIDTH-1:1]};
            if (calc_cnt_r == CALC_LAST) begin
              if (prod_step_s[PW-1:ADDR_WIDTH] != {ADDR_WIDTH{1'b0}}) begin
                err_s   = 1'b1;
                state_s = S_FIN;
              end else begin
                total_s = prod_step_s[ADDR_WIDTH-1:0];
                state_s = S_START;
              end
            end else begin
              calc_cnt_s = calc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        S_START: state_s = S_RUN;
        S_RUN: begin
          cnt_s = cnt_inc_s;
          if (core_we_i && (cnt_inc_s == total_r)) begin
            state_s = S_FIN;
          end else if (core_done_i) begin
            err_s   = 1'b1;
            state_s = S_FIN;
          end else begin
            state_s = S_RUN;
          end
        end
        S_FIN:   state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; strobes are decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt_r   <= 3'd0;
      calc_cnt_r <= {CW{1'b0}};
      sig_len_r  <= {ADDR_WIDTH{1'b0}};
      mcand_r    <= {PW{1'b0}};
      mplier_r   <= {ADDR_WIDTH{1'b0}};
      prod_r     <= {PW{1'b0}};
      config_r   <= {(4*CONFIG_WIDTH){1'b0}};
      total_r    <= {ADDR_WIDTH{1'b0}};
      cnt_r      <= {ADDR_WIDTH{1'b0}};
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      start_r    <= 1'b0;
      cfg_rd_r   <= 1'b0;
      cfg_addr_r <= 2'd0;
    end else begin
      ld_cnt_r   <= ld_cnt_s;
      calc_cnt_r <= calc_cnt_s;
      sig_len_r  <= sig_len_s;
      mcand_r    <= mcand_s;
      mplier_r   <= mplier_s;
      prod_r     <= prod_s;
      config_r   <= config_s;
      total_r    <= total_s;
      cnt_r      <= cnt_s;
      err_r      <= err_s;
      busy_r     <= (state_s != S_IDLE);
      done_r     <= (state_s == S_FIN);
      start_r    <= (state_s == S_START);
      cfg_rd_r   <= cfg_rd_s;
      cfg_addr_r <= cfg_rd_s ? ld_cnt_s[1:0] : 2'd0;
    end
  end

  assign cfg_rd_o     = cfg_rd_r;
  assign cfg_addr_o   = cfg_addr_r;
  assign config_reg_o = config_r;
  assign core_start_o = start_r;
  assign total_len_o  = total_r;
  assign out_cnt_o    = cnt_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule
